// File: rtl/fp_norm_pkg.sv
// Shared constants and result type for the single-precision post-add normalizer.
package fp_norm_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = FRAC_W + 2;
  localparam int EXP_MAX = 255;
  localparam int LZ_W    = $clog2(FRAC_W + 2);

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } norm_res_t;

endpackage

// File: rtl/fp_lzc24.sv
// Leading-zero counter over the 24-bit hidden+fraction field; count is 24 when all bits are zero.
module fp_lzc24
  import fp_norm_pkg::*;
(
  input  logic [FRAC_W:0]   value,
  output logic [LZ_W-1:0]   count,
  output logic              zero
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count = LZ_W'(FRAC_W + 1);
    zero  = 1'b1;
    // Scan upward so the highest set bit is the last one to write the count.
    for (int i = 0; i <= FRAC_W; i++) begin
      if (value[i]) begin
        count = LZ_W'(FRAC_W - i);
        zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// One-stage normalizer for the FP adder result: carry right-shift, leading-zero left-shift,
// Inf/NaN pass-through and gradual underflow. Define NORM_FTZ_EN to flush exp_o==0 results to zero.
module fp_normalizer
  import fp_norm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [MANT_W-1:0] mant_i,
  output logic              valid_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [MANT_W-1:0] mant_o
);

  logic [LZ_W-1:0]  lz;
  logic             lz_zero;
  logic [EXP_W:0]   exp_ext;
  logic [EXP_W:0]   exp_inc;
  logic [EXP_W:0]   lz_ext;
  logic [LZ_W-1:0]  shamt;
  logic [FRAC_W:0]  shifted;
  norm_res_t        res;

  fp_lzc24 u_lzc (
    .value (mant_i[FRAC_W:0]),
    .count (lz),
    .zero  (lz_zero)
  );

  // One extra exponent bit so carry overflow and shift underflow never wrap.
  assign exp_ext = {1'b0, exp_i};
  assign exp_inc = exp_ext + 1'b1;
  assign lz_ext  = (EXP_W + 1)'(lz);

  always_comb begin
    res     = '0;
    shamt   = '0;
    shifted = '0;
    if (exp_i == EXP_W'(EXP_MAX)) begin
      res.exp  = EXP_W'(EXP_MAX);
      res.mant = {mant_i[FRAC_W-1:0], 2'b00};
    end else if (mant_i == '0) begin
      res = '0;
    end else if (mant_i[MANT_W-1]) begin
      if (exp_inc >= (EXP_W + 1)'(EXP_MAX)) begin
        res.exp  = EXP_W'(EXP_MAX);
        res.mant = '0;
      end else begin
        res.exp  = exp_inc[EXP_W-1:0];
        res.mant = {mant_i[MANT_W-2:1], mant_i[0], 1'b0};
      end
    end else if (mant_i[MANT_W-2]) begin
      res.exp  = exp_i;
      res.mant = {mant_i[FRAC_W-1:0], 2'b00};
    end else begin
      if (exp_ext > lz_ext) begin
        shamt   = lz;
        res.exp = EXP_W'(exp_ext - lz_ext);
      end else begin
        // Underflow: here exp_i <= lz, so exp_i-1 always fits the shift width.
        shamt   = (exp_i == '0) ? '0 : LZ_W'(exp_i - 1'b1);
        res.exp = '0;
      end
      shifted  = mant_i[FRAC_W:0] << shamt;
      res.mant = {shifted[FRAC_W-1:0], 2'b00};
    end
`ifdef NORM_FTZ_EN
    if (res.exp == '0) res.mant = '0;
`else
    res.mant = res.mant;
`endif
  end

  always_ff @(posedge clk_i) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
    if (rst_i) begin
      valid_o <= 1'b0;
      exp_o   <= '0;
      mant_o  <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        exp_o  <= res.exp;
        mant_o <= res.mant;
      end
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: directed vectors push expectations, a monitor pops and compares.
module tb_fp_normalizer;
  import fp_norm_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic [EXP_W-1:0]  exp_i;
  logic [MANT_W-1:0] mant_i;
  logic              valid_o;
  logic [EXP_W-1:0]  exp_o;
  logic [MANT_W-1:0] mant_o;

  typedef struct {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    int                cyc;
    string             name;
  } exp_t;

  exp_t queue_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  fp_normalizer dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .exp_i   (exp_i),
    .mant_i  (mant_i),
    .valid_o (valid_o),
    .exp_o   (exp_o),
    .mant_o  (mant_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Drive one vector on a negedge and push its hand-computed result.
  task automatic issue(input string name, input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m,
                       input logic [EXP_W-1:0] ee, input logic [MANT_W-1:0] em);
    exp_t x;
`ifdef NORM_FTZ_EN
    if (ee == '0) em = '0;
`endif
    x.exp = ee; x.mant = em; x.cyc = cycle; x.name = name;
    queue_q.push_back(x);
    valid_i = 1'b1; exp_i = e; mant_i = m;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  // Monitor: whenever valid_o is seen, pop and compare, including the one-cycle latency.
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      if (queue_q.size() == 0) begin
        check("unexpected_valid", 64'(valid_o), 64'd0);
      end else begin
        exp_t x;
        x = queue_q.pop_front();
        check({x.name, "_exp"},  64'(exp_o),  64'(x.exp));
        check({x.name, "_mant"}, 64'(mant_o), 64'(x.mant));
        check({x.name, "_lat"},  64'(cycle),  64'(x.cyc + 1));
      end
    end
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; exp_i = '0; mant_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_exp",   64'(exp_o),   64'd0);
    check("reset_mant",  64'(mant_o),  64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    issue("normal",    8'h80, 25'h0C00000, 8'h80, 25'h1000000);
    issue("carry",     8'h7F, 25'h1000001, 8'h80, 25'h0000002);
    issue("lshift",    8'h85, 25'h0200000, 8'h83, 25'h0000000);
    issue("underflow", 8'h02, 25'h0000100, 8'h00, 25'h0000800);
    issue("overflow",  8'hFE, 25'h1000000, 8'hFF, 25'h0000000);
    issue("nan",       8'hFF, 25'h0800001, 8'hFF, 25'h0000004);
    issue("zero",      8'h40, 25'h0000000, 8'h00, 25'h0000000);
    idle(2);
    issue("denorm_in", 8'h00, 25'h0000010, 8'h00, 25'h0000040);
    issue("exp_eq_s",  8'h01, 25'h0400000, 8'h00, 25'h1000000);
    issue("exp_gt_s",  8'h03, 25'h0400000, 8'h02, 25'h0000000);
    issue("lsb_only",  8'h80, 25'h0000001, 8'h69, 25'h0000000);
    issue("carry_max", 8'hFD, 25'h1FFFFFF, 8'hFE, 25'h1FFFFFE);
    issue("inf_zero",  8'hFF, 25'h0000000, 8'hFF, 25'h0000000);
    issue("inf_carry", 8'hFF, 25'h1FFFFFF, 8'hFF, 25'h1FFFFFC);
    idle(3);
    check("hold_valid", 64'(valid_o), 64'd0);
    check("hold_exp",   64'(exp_o),   64'hFF);
    check("hold_mant",  64'(mant_o),  64'h1FFFFFC);

    // Reset asserted together with a valid sample must discard the sample.
    valid_i = 1'b1; exp_i = 8'h80; mant_i = 25'h0C00000; rst_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; rst_i = 1'b0;
    check("rst_valid_valid", 64'(valid_o), 64'd0);
    check("rst_valid_exp",   64'(exp_o),   64'd0);
    check("rst_valid_mant",  64'(mant_o),  64'd0);

    for (int i = 0; i < 20 && queue_q.size() != 0; i++) @(negedge clk_i);
    check("queue_drained", 64'(queue_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
